// File: rtl/nobl_fifo_pkg.sv
// nobl_fifo_pkg: shared constants and types for the multi-channel NoBL FIFO
package nobl_fifo_pkg;
   localparam int DEFAULT_RD_LAT = 4;
   localparam int TAG_CHAN_W     = 3;

   typedef struct packed {
      logic                  valid;
      logic [TAG_CHAN_W-1:0] chan;
   } tag_t;

   function automatic int count_width(input int ram_depth, input int chan_bits);
      return ram_depth - chan_bits + 1;
   endfunction
endpackage

// File: rtl/nobl_if.sv
// nobl_if: ZBT/NoBL SRAM pin driver; read data returns four clocks after the request
module nobl_if #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] RAM_D_pi,
   output logic [WIDTH-1:0] RAM_D_po,
   output logic             RAM_D_poe,
   output logic [DEPTH-1:0] RAM_A,
   output logic             RAM_WEn,
   output logic             RAM_CENn,
   output logic             RAM_LDn,
   output logic             RAM_OEn,
   output logic             RAM_CE1n,
   input  logic [DEPTH-1:0] address,
   input  logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] data_in,
   input  logic             write,
   input  logic             enable
);
   logic [DEPTH-1:0] r_a;
   logic             r_wen, r_ldn;
   logic [2:0]       r_we;
   logic [WIDTH-1:0] r_wd [3];
   logic [WIDTH-1:0] r_din;

   // register the command, delay write data to the SRAM's two-cycle data phase, capture read data
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_a   <= '0;
         r_wen <= 1'b1;
         r_ldn <= 1'b1;
         r_we  <= '0;
         for (int s = 0; s < 3; s++) r_wd[s] <= '0;
         r_din <= '0;
      end else begin
         r_a     <= address;
         r_wen   <= !(enable && write);
         r_ldn   <= !enable;
         r_we    <= {r_we[1:0], enable && write};
         r_wd[0] <= data_out;
         r_wd[1] <= r_wd[0];
         r_wd[2] <= r_wd[1];
         r_din   <= RAM_D_pi;
      end

   assign RAM_A     = r_a;
   assign RAM_WEn   = r_wen;
   assign RAM_LDn   = r_ldn;
   assign RAM_CENn  = 1'b0;
   assign RAM_OEn   = 1'b0;
   assign RAM_CE1n  = 1'b0;
   assign RAM_D_po  = r_wd[2];
   assign RAM_D_poe = r_we[2];
   assign data_in   = r_din;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search restarts just past the last winner
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_adv,
   output logic [N-1:0] o_grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr, w_idx, w_try;
   logic          w_found;

   // first requester at or after the pointer wins; N is a power of two so indices wrap naturally
   always_comb begin
      w_idx   = r_ptr;
      w_try   = r_ptr;
      w_found = 1'b0;
      o_grant = '0;
      for (int k = 0; k < N; k++) begin
         w_try = r_ptr + PW'(k);
         if (!w_found && i_req[w_try]) begin
            w_found = 1'b1;
            w_idx   = w_try;
         end
      end
      if (w_found) o_grant[w_idx] = 1'b1;
   end

   // advance past the winner only when something was granted
   always_ff @(posedge clk or posedge rst)
      if (rst) r_ptr <= '0;
      else if (i_adv && w_found) r_ptr <= w_idx + PW'(1);
endmodule

// File: rtl/nobl_mchan_fifo.sv
// nobl_mchan_fifo: per-channel circular FIFOs sharing one NoBL SRAM, one operation per clock
module nobl_mchan_fifo
   import nobl_fifo_pkg::*;
#(
   parameter int  WIDTH     = 18,
   parameter int  RAM_DEPTH = 19,
   parameter int  CHAN_BITS = 1,
   parameter int  RD_LAT    = DEFAULT_RD_LAT,
   localparam int NCHAN     = 1 << CHAN_BITS,
   localparam int R         = RAM_DEPTH - CHAN_BITS,
   localparam int C         = count_width(RAM_DEPTH, CHAN_BITS),
   localparam int CB        = (CHAN_BITS > 0) ? CHAN_BITS : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       RAM_D_pi,
   output logic [WIDTH-1:0]       RAM_D_po,
   output logic                   RAM_D_poe,
   output logic [RAM_DEPTH-1:0]   RAM_A,
   output logic                   RAM_WEn,
   output logic                   RAM_CENn,
   output logic                   RAM_LDn,
   output logic                   RAM_OEn,
   output logic                   RAM_CE1n,
   input  logic [NCHAN*WIDTH-1:0] write_data,
   input  logic [NCHAN-1:0]       write_strobe,
   output logic [NCHAN-1:0]       write_ack,
   input  logic [NCHAN-1:0]       read_strobe,
   output logic [NCHAN-1:0]       read_ack,
   output logic [WIDTH-1:0]       read_data,
   output logic [CB-1:0]          read_chan,
   output logic                   data_avail,
   output logic [NCHAN-1:0]       space_avail,
   output logic [NCHAN-1:0]       not_empty,
   output logic [NCHAN*C-1:0]     free_count
);
   localparam logic [C-1:0] EMPTY_FREE = {1'b1, {R{1'b0}}};

   logic [2*NCHAN-1:0]   w_req, w_grant;
   logic [CB-1:0]        w_chan;
   logic                 w_wr, w_op;
   logic [R-1:0]         w_ptr;
   logic [RAM_DEPTH-1:0] w_addr;
   logic [WIDTH-1:0]     w_wdata;
   logic [C-1:0]         w_free_nxt [NCHAN];
   logic [R-1:0]         r_wr_ptr [NCHAN];
   logic [R-1:0]         r_rd_ptr [NCHAN];
   logic [C-1:0]         r_free [NCHAN];
   logic [NCHAN-1:0]     r_space, r_ne;
   tag_t                 r_tag [RD_LAT];

   // requests are only eligible when the channel can honour them; nothing is eligible in reset
   assign w_req = rst ? '0 : {read_strobe & r_ne, write_strobe & r_space};

   rr_arbiter #(.N(2 * NCHAN)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_req   (w_req),
      .i_adv   (1'b1),
      .o_grant (w_grant)
   );

   assign write_ack = w_grant[NCHAN-1:0];
   assign read_ack  = w_grant[2*NCHAN-1:NCHAN];
   assign w_op      = |w_grant;

   // decode the single granted operation and each channel's next free count
   always_comb begin
      w_chan = '0;
      w_wr   = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (write_ack[i] || read_ack[i]) begin
            w_chan = CB'(i);
            w_wr   = write_ack[i];
         end
         w_free_nxt[i] = write_ack[i] ? r_free[i] - 1'b1 :
                         read_ack[i]  ? r_free[i] + 1'b1 : r_free[i];
      end
   end

   assign w_ptr   = w_wr ? r_wr_ptr[w_chan] : r_rd_ptr[w_chan];
   assign w_addr  = (RAM_DEPTH'(w_chan) << R) | RAM_DEPTH'(w_ptr);
   assign w_wdata = write_data[w_chan*WIDTH +: WIDTH];

   // pointers and counts; flags come from the next-state count so they are exact
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NCHAN; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_free[i]   <= EMPTY_FREE;
         end
         r_space <= '1;
         r_ne    <= '0;
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            if (write_ack[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
            if (read_ack[i]) r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
            r_free[i]  <= w_free_nxt[i];
            r_space[i] <= w_free_nxt[i] != '0;
            r_ne[i]    <= w_free_nxt[i] != EMPTY_FREE;
         end
      end

   // tag pipeline tracks which channel each in-flight read belongs to; reset drops them all
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int s = 0; s < RD_LAT; s++) r_tag[s] <= '0;
      end else begin
         r_tag[0].valid <= |read_ack;
         r_tag[0].chan  <= TAG_CHAN_W'(w_chan);
         for (int s = 1; s < RD_LAT; s++) r_tag[s] <= r_tag[s-1];
      end

   assign data_avail  = r_tag[RD_LAT-1].valid;
   assign read_chan   = CB'(r_tag[RD_LAT-1].chan);
   assign space_avail = r_space;
   assign not_empty   = r_ne;

   for (genvar g = 0; g < NCHAN; g++) begin : g_free
      assign free_count[g*C +: C] = r_free[g];
   end

   nobl_if #(.WIDTH(WIDTH), .DEPTH(RAM_DEPTH)) u_nobl (
      .clk       (clk),
      .rst       (rst),
      .RAM_D_pi  (RAM_D_pi),
      .RAM_D_po  (RAM_D_po),
      .RAM_D_poe (RAM_D_poe),
      .RAM_A     (RAM_A),
      .RAM_WEn   (RAM_WEn),
      .RAM_CENn  (RAM_CENn),
      .RAM_LDn   (RAM_LDn),
      .RAM_OEn   (RAM_OEn),
      .RAM_CE1n  (RAM_CE1n),
      .address   (w_addr),
      .data_out  (w_wdata),
      .data_in   (read_data),
      .write     (w_wr),
      .enable    (w_op)
   );
endmodule

// File: tb/tb_nobl_mchan_fifo.sv
// tb_nobl_mchan_fifo: scoreboard bench for the multi-channel NoBL FIFO with a ZBT SRAM model
module tb_nobl_mchan_fifo;
   localparam int WIDTH = 18, RAM_DEPTH = 6, CHAN_BITS = 1, RD_LAT = 4, NCHAN = 2, C = 6;

   logic                   clk = 1'b0, rst = 1'b1;
   logic [WIDTH-1:0]       RAM_D_pi, RAM_D_po;
   logic                   RAM_D_poe, RAM_WEn, RAM_CENn, RAM_LDn, RAM_OEn, RAM_CE1n;
   logic [RAM_DEPTH-1:0]   RAM_A;
   logic [NCHAN*WIDTH-1:0] write_data = '0;
   logic [NCHAN-1:0]       write_strobe = '0, read_strobe = '0, write_ack, read_ack;
   logic [WIDTH-1:0]       read_data;
   logic                   read_chan, data_avail;
   logic [NCHAN-1:0]       space_avail, not_empty;
   logic [NCHAN*C-1:0]     free_count;

   always #5 clk = ~clk;

   nobl_mchan_fifo #(.WIDTH(WIDTH), .RAM_DEPTH(RAM_DEPTH), .CHAN_BITS(CHAN_BITS), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .RAM_D_pi(RAM_D_pi), .RAM_D_po(RAM_D_po), .RAM_D_poe(RAM_D_poe),
      .RAM_A(RAM_A), .RAM_WEn(RAM_WEn), .RAM_CENn(RAM_CENn), .RAM_LDn(RAM_LDn), .RAM_OEn(RAM_OEn),
      .RAM_CE1n(RAM_CE1n), .write_data(write_data), .write_strobe(write_strobe), .write_ack(write_ack),
      .read_strobe(read_strobe), .read_ack(read_ack), .read_data(read_data), .read_chan(read_chan),
      .data_avail(data_avail), .space_avail(space_avail), .not_empty(not_empty), .free_count(free_count)
   );

   // pipelined ZBT SRAM: address sampled at one edge, data phase two edges later
   logic [WIDTH-1:0]     mem [64];
   logic [RAM_DEPTH-1:0] s_a1, s_a2;
   logic                 s_v1 = 1'b0, s_v2 = 1'b0, s_w1 = 1'b0, s_w2 = 1'b0;
   always @(posedge clk) begin
      s_a1 <= RAM_A;
      s_v1 <= !RAM_LDn && !RAM_CENn;
      s_w1 <= !RAM_WEn;
      s_a2 <= s_a1;
      s_v2 <= s_v1;
      s_w2 <= s_w1;
      if (s_v2 && s_w2 && RAM_D_poe) mem[s_a2] <= RAM_D_po;
   end
   assign RAM_D_pi = (s_v2 && !s_w2) ? mem[s_a2] : '0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   typedef struct {int chan; logic [WIDTH-1:0] data; int due;} exp_t;
   exp_t             sb[$];
   exp_t             e;
   logic [WIDTH-1:0] mq0[$], mq1[$];
   logic [1:0]       l_wack, l_rack, l_space, l_ne;
   logic [5:0]       l_addr;
   logic             l_ldn, l_dav;

   // scoreboard: every data_avail must match the oldest outstanding read, on its due cycle
   always @(negedge clk) begin
      if (data_avail) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_data: data_avail=1 chan=%0d data=%h cyc=%0d, required no output", read_chan, read_data, cyc);
         end else begin
            e = sb.pop_front();
            if (read_data !== e.data || read_chan !== e.chan[0] || cyc != e.due) begin
               errors++;
               $display("FAIL read_data: got chan=%0d data=%h cyc=%0d, required chan=%0d data=%h cyc=%0d",
                        read_chan, read_data, cyc, e.chan, e.data, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_data: data_avail=0 at cyc=%0d, required chan=%0d data=%h at cyc=%0d", cyc, sb[0].chan, sb[0].data, sb[0].due);
         void'(sb.pop_front());
      end
   end

   // one clock: sample at negedge, update the FIFO model, return just after the next posedge
   task automatic tick();
      logic [WIDTH-1:0] d;
      @(negedge clk);
      l_wack = write_ack; l_rack = read_ack; l_space = space_avail; l_ne = not_empty;
      l_addr = RAM_A; l_ldn = RAM_LDn; l_dav = data_avail;
      if (l_wack[0]) mq0.push_back(write_data[17:0]);
      if (l_wack[1]) mq1.push_back(write_data[35:18]);
      if (l_rack[0]) begin
         d = (mq0.size() > 0) ? mq0.pop_front() : {WIDTH{1'bx}};
         sb.push_back(exp_t'{0, d, cyc + RD_LAT});
      end
      if (l_rack[1]) begin
         d = (mq1.size() > 0) ? mq1.pop_front() : {WIDTH{1'bx}};
         sb.push_back(exp_t'{1, d, cyc + RD_LAT});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
   endtask

   task automatic test_reset();
      write_strobe = 2'b11; read_strobe = 2'b11;
      @(negedge clk);
      checks++; if (free_count !== {6'd32, 6'd32}) begin errors++; $display("FAIL reset_free: got %h, required %h", free_count, {6'd32, 6'd32}); end
      checks++; if (space_avail !== 2'b11) begin errors++; $display("FAIL reset_space: got %b, required 11", space_avail); end
      checks++; if (not_empty !== 2'b00) begin errors++; $display("FAIL reset_not_empty: got %b, required 00", not_empty); end
      checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL reset_data_avail: got %b, required 0", data_avail); end
      checks++; if ({write_ack, read_ack} !== 4'b0) begin errors++; $display("FAIL reset_acks: got %b, required 0000", {write_ack, read_ack}); end
      write_strobe = '0; read_strobe = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_fill();
      int n = 0, k;
      write_strobe = 2'b01;
      for (int i = 0; i < 36; i++) begin
         write_data[17:0] = 18'h200 + 18'(n);
         k = n;
         tick();
         checks++; if (l_wack[0] !== (k < 32)) begin errors++; $display("FAIL fill_ack: after %0d acks got %b, required %b", k, l_wack[0], k < 32); end
         checks++; if (l_space[0] !== (k < 32)) begin errors++; $display("FAIL fill_space: after %0d acks got %b, required %b", k, l_space[0], k < 32); end
         if (l_wack[0]) n++;
      end
      write_strobe = '0;
      tick();
      checks++; if (n != 32) begin errors++; $display("FAIL fill_count: got %0d acks, required 32", n); end
      checks++; if (free_count !== {6'd32, 6'd0}) begin errors++; $display("FAIL fill_free: got %h, required %h", free_count, {6'd32, 6'd0}); end
      checks++; if (space_avail !== 2'b10) begin errors++; $display("FAIL fill_space_vec: got %b, required 10", space_avail); end
      checks++; if (not_empty !== 2'b01) begin errors++; $display("FAIL fill_not_empty: got %b, required 01", not_empty); end
      read_strobe = 2'b01;
      for (int i = 0; i < 40 && not_empty[0]; i++) tick();
      read_strobe = '0;
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_drain: %0d reads outstanding, required 0", sb.size()); end
      checks++; if (free_count[5:0] !== 6'd32) begin errors++; $display("FAIL fill_empty_free: got %0d, required 32", free_count[5:0]); end
   endtask

   task automatic test_ch1_read();
      int n = 0;
      write_strobe = 2'b10;
      for (int i = 0; i < 20 && n < 4; i++) begin
         write_data[35:18] = 18'h101 + 18'(n);
         tick();
         if (l_wack[1]) n++;
      end
      write_strobe = '0;
      checks++; if (n != 4) begin errors++; $display("FAIL ch1_writes: got %0d acks, required 4", n); end
      n = 0;
      read_strobe = 2'b10;
      for (int i = 0; i < 20 && n < 4; i++) begin
         tick();
         if (l_rack[1]) n++;
      end
      read_strobe = '0;
      checks++; if (n != 4) begin errors++; $display("FAIL ch1_reads: got %0d acks, required 4", n); end
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL ch1_drain: %0d reads outstanding, required 0", sb.size()); end
      checks++; if (not_empty !== 2'b00) begin errors++; $display("FAIL ch1_not_empty: got %b, required 00", not_empty); end
   endtask

   task automatic test_round_robin();
      int prev = -1, idx;
      logic [3:0] g;
      write_strobe = 2'b11;
      for (int i = 0; i < 16; i++) begin
         write_data = {18'h1100 + 18'(i), 18'h0100 + 18'(i)};
         tick();
      end
      read_strobe = 2'b11;
      for (int i = 0; i < 16; i++) begin
         write_data = {18'h1200 + 18'(i), 18'h0200 + 18'(i)};
         tick();
         g = {l_rack, l_wack};
         checks++;
         if ($countones(g) != 1) begin
            errors++; $display("FAIL rr_onehot: grants %b, required exactly one", g);
         end else begin
            idx = g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : 3;
            if (prev >= 0) begin
               checks++;
               if (idx != (prev + 1) % 4) begin errors++; $display("FAIL rr_order: granted %0d, required %0d", idx, (prev + 1) % 4); end
            end
            prev = idx;
         end
      end
      write_strobe = '0; read_strobe = '0;
      checks++; if (free_count !== {6'd24, 6'd24}) begin errors++; $display("FAIL rr_free: got %h, required %h", free_count, {6'd24, 6'd24}); end
      read_strobe = 2'b11;
      for (int i = 0; i < 60 && |not_empty; i++) tick();
      read_strobe = '0;
      drain();
      checks++; if (sb.size() != 0 || not_empty !== 2'b00) begin errors++; $display("FAIL rr_drain: outstanding %0d not_empty %b, required 0 and 00", sb.size(), not_empty); end
   endtask

   task automatic test_wrap();
      int n = 0;
      logic got;
      write_strobe = 2'b10;
      for (int i = 0; i < 10 && n < 2; i++) begin
         write_data[35:18] = (n == 0) ? 18'h1AA : 18'h1BB;
         tick();
         if (l_wack[1]) n++;
      end
      write_strobe = '0;
      tick();
      for (int p = 0; p < 100; p++) begin
         write_data[17:0] = 18'h3000 + 18'(p);
         write_strobe = 2'b01;
         got = 1'b0;
         for (int j = 0; j < 5 && !got; j++) begin
            tick();
            got = l_wack[0];
            if (!l_ldn) begin checks++; if (l_addr[5] !== 1'b0) begin errors++; $display("FAIL wrap_addr: address %0d, required 0..31", l_addr); end end
         end
         write_strobe = '0;
         read_strobe = 2'b01;
         got = 1'b0;
         for (int j = 0; j < 5 && !got; j++) begin
            tick();
            got = l_rack[0];
            if (!l_ldn) begin checks++; if (l_addr[5] !== 1'b0) begin errors++; $display("FAIL wrap_addr: address %0d, required 0..31", l_addr); end end
         end
         read_strobe = '0;
         if (!got) begin checks++; errors++; $display("FAIL wrap_pass: pass %0d got no read ack, required one", p); end
      end
      drain();
      checks++; if (free_count !== {6'd30, 6'd32}) begin errors++; $display("FAIL wrap_free: got %h, required %h", free_count, {6'd30, 6'd32}); end
      read_strobe = 2'b10;
      for (int i = 0; i < 10 && not_empty[1]; i++) tick();
      read_strobe = '0;
      drain();
      checks++; if (sb.size() != 0 || not_empty !== 2'b00) begin errors++; $display("FAIL wrap_drain: outstanding %0d not_empty %b, required 0 and 00", sb.size(), not_empty); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      write_strobe = 2'b01;
      for (int i = 0; i < 10 && n < 3; i++) begin
         write_data[17:0] = 18'h55 + 18'(n);
         tick();
         if (l_wack[0]) n++;
      end
      write_strobe = '0;
      tick();
      n = 0;
      read_strobe = 2'b01;
      for (int i = 0; i < 10 && n < 3; i++) begin
         tick();
         if (l_rack[0]) n++;
      end
      read_strobe = '0;
      checks++; if (n != 3) begin errors++; $display("FAIL mid_reads: got %0d acks, required 3", n); end
      rst = 1'b1;
      sb.delete(); mq0.delete(); mq1.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL mid_rst_avail: got %b, required 0", data_avail); end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (l_dav !== 1'b0) begin errors++; $display("FAIL mid_post_avail: got %b, required 0", l_dav); end
      end
      checks++; if (free_count !== {6'd32, 6'd32}) begin errors++; $display("FAIL mid_free: got %h, required %h", free_count, {6'd32, 6'd32}); end
      checks++; if (space_avail !== 2'b11 || not_empty !== 2'b00) begin errors++; $display("FAIL mid_flags: space %b not_empty %b, required 11 and 00", space_avail, not_empty); end
      checks++; if (read_chan !== 1'b0) begin errors++; $display("FAIL mid_read_chan: got %b, required 0", read_chan); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_ch1_read();
      test_round_robin();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
